// File: rtl/mger_product_assembler.sv
// -----------------------------------------------------------------------------
// mger_product_assembler
//
// Output stage of the MGER 8x8 approximate multiplier. It combines the
// high-block product, the summed cross-block term and the low-block term into
// the 16-bit result
//     product = {s_high,8'b0} + {s_mid,4'b0} + s_low
// over two registered stages. Both stages use valid/ready backpressure, and the
// block counts every delivered result.
//
// Optional build macro: MGER_COMP_EN
//   When this macro is defined, results flagged as approximate get COMP_VAL
//   added in stage 2, and the sum saturates at 16'hFFFF. When it is undefined,
//   in_approx and COMP_VAL are ignored.
//
// Parameters
//   CNT_W     width of the delivered-result counter
//   COMP_VAL  compensation constant (used only with MGER_COMP_EN)
//
// Ports
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset; clears all state
//   in_valid   upstream operands present
//   in_ready   block accepts operands this cycle (combinational from out_ready)
//   s_high     A_H*B_H, 0..225
//   s_mid      A_H*B_L + A_L*B_H, 0..450
//   s_low      low-block product, 0..225
//   in_approx  s_low/s_mid came from an approximate path
//   out_valid  product valid
//   out_ready  downstream consumes product
//   product    assembled 16-bit product
//   done_cnt   delivered results, modulo 2^CNT_W
// -----------------------------------------------------------------------------
module mger_product_assembler #(
    parameter int          CNT_W    = 8,
    parameter logic [15:0] COMP_VAL = 16'd8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       s_high,
    input  logic [8:0]       s_mid,
    input  logic [7:0]       s_low,
    input  logic             in_approx,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      product,
    output logic [CNT_W-1:0] done_cnt
);

    // Clamp a 17-bit sum to the 16-bit output range.
    function automatic logic [15:0] sat16(input logic [16:0] v);
        return v[16] ? 16'hFFFF : v[15:0];
    endfunction

    logic        vld_p1;
    logic [15:0] sum_hm_p1;
    logic [7:0]  low_p1;
    logic        s1_load;
    logic        s2_load;
    logic [15:0] product_nxt;

    // Each stage may load when it is empty or when the stage behind it
    // empties in this same cycle. This makes in_ready depend on out_ready
    // combinationally, so a stall release causes no bubble.
    assign s2_load  = !out_valid || out_ready;
    assign s1_load  = !vld_p1 || s2_load;
    assign in_ready = s1_load;

`ifdef MGER_COMP_EN
    logic approx_p1;

    always_comb begin
        product_nxt = sat16({1'b0, sum_hm_p1} + {9'b0, low_p1}
                            + (approx_p1 ? {1'b0, COMP_VAL} : 17'd0));
    end
`else
    // These inputs only matter in the compensated build.
    logic unused_cfg;
    assign unused_cfg = ^{in_approx, COMP_VAL};

    // The maximum is 64800 + 225 = 65025, so the 16-bit sum cannot overflow.
    always_comb begin
        product_nxt = sum_hm_p1 + {8'b0, low_p1};
    end
`endif

    // ---- stage 1: high + shifted cross term ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1    <= 1'b0;
            sum_hm_p1 <= 16'd0;
            low_p1    <= 8'd0;
        end else if (s1_load) begin
            vld_p1 <= in_valid;
            if (in_valid) begin
                sum_hm_p1 <= {s_high, 8'b0} + {3'b0, s_mid, 4'b0};
                low_p1    <= s_low;
            end
        end
    end

`ifdef MGER_COMP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            approx_p1 <= 1'b0;
        end else if (s1_load && in_valid) begin
            approx_p1 <= in_approx;
        end
    end
`endif

    // ---- stage 2: add low term (and compensation), register output ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            product   <= 16'd0;
        end else if (s2_load) begin
            out_valid <= vld_p1;
            if (vld_p1) begin
                product <= product_nxt;
            end
        end
    end

    // ---- delivery counter ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_cnt <= '0;
        end else if (out_valid && out_ready) begin
            done_cnt <= done_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_mger_product_assembler.sv
module tb_mger_product_assembler;

    localparam int          CNT_W    = 4;
    localparam logic [15:0] COMP_VAL = 16'd1000;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       s_high;
    logic [8:0]       s_mid;
    logic [7:0]       s_low;
    logic             in_approx;
    logic             out_valid;
    logic             out_ready;
    logic [15:0]      product;
    logic [CNT_W-1:0] done_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    mger_product_assembler #(.CNT_W(CNT_W), .COMP_VAL(COMP_VAL)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .s_high    (s_high),
        .s_mid     (s_mid),
        .s_low     (s_low),
        .in_approx (in_approx),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .done_cnt  (done_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] h, input logic [8:0] m,
                         input logic [7:0] l, input logic a);
        in_valid  = v;
        s_high    = h;
        s_mid     = m;
        s_low     = l;
        in_approx = a;
    endtask

    // Streaming vectors with hand-computed products.
    logic [7:0]  vh [8] = '{8'd6, 8'd0, 8'd1, 8'd15, 8'd0,   8'd0,   8'd100, 8'd225};
    logic [8:0]  vm [8] = '{9'd0, 9'd0, 9'd1, 9'd15, 9'd450, 9'd0,   9'd200, 9'd0};
    logic [7:0]  vl [8] = '{8'd0, 8'd0, 8'd1, 8'd15, 8'd0,   8'd225, 8'd50,  8'd225};
    logic [15:0] vp [8] = '{16'h0600, 16'h0000, 16'h0111, 16'h0FFF,
                            16'h1C20, 16'h00E1, 16'h70B2, 16'hE1E1};

    initial begin
        // ---------------- reset with random inputs ----------------
        rst_n     = 1'b0;
        out_ready = 1'b0;
        drive(1'b1, 8'($urandom), 9'($urandom), 8'($urandom), 1'b1);
        tick();
        tick();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_product",   32'(product),   32'd0);
        chk("rst_done_cnt",  32'(done_cnt),  32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);

        drive(1'b0, 8'd0, 9'd0, 8'd0, 1'b0);
        rst_n = 1'b1;
        tick();

        // ---------------- max operands ----------------
        out_ready = 1'b1;
        drive(1'b1, 8'd225, 9'd450, 8'd225, 1'b0);
        #1 chk("max_in_ready", 32'(in_ready), 32'd1);
        tick();
        chk("max_lat_not_yet", 32'(out_valid), 32'd0);
        drive(1'b0, 8'd0, 9'd0, 8'd0, 1'b0);
        tick();
        chk("max_out_valid", 32'(out_valid), 32'd1);
        chk("max_product",   32'(product),   32'hFE01);
        tick();
        chk("max_done_cnt",  32'(done_cnt),  32'd1);
        chk("max_drained",   32'(out_valid), 32'd0);

        // ---------------- streaming, out_ready high ----------------
        for (int i = 0; i <= 8; i++) begin
            if (i < 8) drive(1'b1, vh[i], vm[i], vl[i], 1'b0);
            else       drive(1'b0, 8'd0, 9'd0, 8'd0, 1'b0);
            #1 chk($sformatf("stream_in_ready_%0d", i), 32'(in_ready), 32'd1);
            tick();
            if (i >= 1) begin
                chk($sformatf("stream_valid_%0d", i - 1),   32'(out_valid), 32'd1);
                chk($sformatf("stream_product_%0d", i - 1), 32'(product),   32'(vp[i - 1]));
            end
        end
        tick();
        chk("stream_drained",  32'(out_valid), 32'd0);
        chk("stream_done_cnt", 32'(done_cnt),  32'd9);

        // ---------------- backpressure ----------------
        out_ready = 1'b0;
        drive(1'b1, 8'd1, 9'd0, 8'd0, 1'b0);            // A -> 0x0100
        #1 chk("bp_ready_a", 32'(in_ready), 32'd1);
        tick();
        drive(1'b1, 8'd2, 9'd0, 8'd0, 1'b0);            // B -> 0x0200
        #1 chk("bp_ready_b", 32'(in_ready), 32'd1);
        tick();
        drive(1'b1, 8'd3, 9'd0, 8'd0, 1'b0);            // C -> 0x0300
        #1 chk("bp_full_ready", 32'(in_ready), 32'd0);
        chk("bp_valid_a",   32'(out_valid), 32'd1);
        chk("bp_product_a", 32'(product),   32'h0100);
        for (int k = 0; k < 2; k++) begin
            tick();
            chk($sformatf("bp_hold_ready_%0d", k),   32'(in_ready),  32'd0);
            chk($sformatf("bp_hold_valid_%0d", k),   32'(out_valid), 32'd1);
            chk($sformatf("bp_hold_product_%0d", k), 32'(product),   32'h0100);
        end
        out_ready = 1'b1;
        #1 chk("bp_release_ready", 32'(in_ready), 32'd1);
        tick();
        chk("bp_product_b", 32'(product), 32'h0200);
        drive(1'b0, 8'd0, 9'd0, 8'd0, 1'b0);
        tick();
        chk("bp_product_c", 32'(product),   32'h0300);
        chk("bp_valid_c",   32'(out_valid), 32'd1);
        tick();
        chk("bp_drained",  32'(out_valid), 32'd0);
        chk("bp_done_cnt", 32'(done_cnt),  32'd12);

        // ---------------- approximate flag ----------------
        drive(1'b1, 8'd225, 9'd450, 8'd225, 1'b1);
        tick();
        drive(1'b1, 8'd1, 9'd0, 8'd1, 1'b1);
        tick();
`ifdef MGER_COMP_EN
        chk("comp_saturate", 32'(product), 32'hFFFF);
`else
        chk("comp_ignored_max", 32'(product), 32'hFE01);
`endif
        drive(1'b1, 8'd225, 9'd450, 8'd225, 1'b0);
        tick();
`ifdef MGER_COMP_EN
        chk("comp_small", 32'(product), 32'h04E9);   // 257 + 1000
`else
        chk("comp_ignored_small", 32'(product), 32'h0101);
`endif
        drive(1'b0, 8'd0, 9'd0, 8'd0, 1'b0);
        tick();
        chk("comp_exact_max", 32'(product), 32'hFE01);
        tick();
        chk("comp_drained", 32'(out_valid), 32'd0);

        // ---------------- mid-stream reset under stall ----------------
        out_ready = 1'b0;
        drive(1'b1, 8'd4, 9'd0, 8'd0, 1'b0);
        tick();
        drive(1'b1, 8'd5, 9'd0, 8'd0, 1'b0);
        tick();
        drive(1'b0, 8'd0, 9'd0, 8'd0, 1'b0);
        chk("mrst_held_valid",   32'(out_valid), 32'd1);
        chk("mrst_held_product", 32'(product),   32'h0400);
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_async_valid",   32'(out_valid), 32'd0);
        chk("mrst_async_product", 32'(product),   32'd0);
        chk("mrst_async_cnt",     32'(done_cnt),  32'd0);
        chk("mrst_async_ready",   32'(in_ready),  32'd1);
        tick();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        tick();
        drive(1'b1, 8'd7, 9'd0, 8'd0, 1'b0);            // F -> 0x0700
        tick();
        drive(1'b0, 8'd0, 9'd0, 8'd0, 1'b0);
        tick();
        chk("mrst_new_valid",   32'(out_valid), 32'd1);
        chk("mrst_new_product", 32'(product),   32'h0700);
        tick();
        chk("mrst_new_cnt", 32'(done_cnt), 32'd1);
        tick();
        chk("mrst_no_ghost", 32'(out_valid), 32'd0);
        chk("mrst_final_cnt", 32'(done_cnt), 32'd1);

        // ---------------- counter wrap: 17 deliveries ----------------
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, 8'(i), 9'd0, 8'd0, 1'b0);
            tick();
        end
        drive(1'b0, 8'd0, 9'd0, 8'd0, 1'b0);
        tick();
        chk("wrap_cnt_before_last", 32'(done_cnt), 32'd0);
        chk("wrap_last_product",    32'(product),  32'h1000);
        tick();
        chk("wrap_cnt", 32'(done_cnt), 32'd1);
        chk("wrap_drained", 32'(out_valid), 32'd0);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule

// File: doc/mger_product_assembler.md
# mger_product_assembler

Pipelined output stage of the MGER 8x8 approximate multiplier. It sits directly downstream of the 4x4 high-block multiplier and the low/cross-block generators. It accepts the high-block product, the summed cross-block term and the low-block term, then forms the 16-bit product `{s_high,8'b0} + {s_mid,4'b0} + s_low` over two registered stages with valid/ready backpressure. It also counts delivered results.

## Interface
- `CNT_W`, default 8: width of the delivered-result counter.
- `COMP_VAL`, default 16'd8: compensation constant added to approximate results. Used only when `MGER_COMP_EN` is defined.
- `clk` input, 1 bit: clock; all state updates on the rising edge.
- `rst_n` input, 1 bit: reset, asynchronous, active-low.
- `in_valid` input, 1 bit: upstream operands present.
- `in_ready` output, 1 bit: block accepts operands this cycle.
- `s_high` input, 8 bits: A_H*B_H from the high-block multiplier, range 0..225.
- `s_mid` input, 9 bits: A_H*B_L + A_L*B_H, range 0..450.
- `s_low` input, 8 bits: low-block product, exact or approximate, range 0..225.
- `in_approx` input, 1 bit: `s_low`/`s_mid` came from an approximate path.
- `out_valid` output, 1 bit: `product` valid.
- `out_ready` input, 1 bit: downstream consumes `product`.
- `product` output, 16 bits: assembled product.
- `done_cnt` output, `CNT_W` bits: number of results delivered, modulo 2^CNT_W.

## Operation
- Accept on `in_valid && in_ready`.
- Stage 1 registers:
  - `p1 = {s_high,8'b0} + {3'b0,s_mid,4'b0}` (16 bits; max 64800, no overflow);
  - `s1_low = s_low`;
  - `s1_approx = in_approx`;
  - `s1_valid`.
- Stage 2 registers `product = p1 + s1_low` (+ compensation, see Configuration) and `out_valid`.
- Without compensation the sum is unsigned 16-bit and cannot overflow (max 65025).
- Load enables:
  - `s2_load = !out_valid || out_ready`;
  - `s1_load = !s1_valid || s2_load`;
  - `in_ready = s1_load` (combinational from `out_ready`; this ready path is intentionally unregistered).
- On `s2_load`:
  - `out_valid <= s1_valid`;
  - `product` updates only when `s1_valid`, otherwise it holds.
- On `s1_load`: `s1_valid <= in_valid`; stage-1 data registers load only when `in_valid`.
- While `out_valid && !out_ready`, `product` and `out_valid` are held stable.
- `done_cnt` increments by 1 on each `out_valid && out_ready`. It wraps from 2^CNT_W-1 to 0.
- Accept and delivery in the same cycle are both honoured.
- Reset (any time, including mid-stream):
  - `s1_valid`, `out_valid`, `product`, `p1`, `s1_low`, `s1_approx` and `done_cnt` clear to 0;
  - in-flight data is discarded;
  - `in_ready` is 1 immediately after reset is asserted.

## Timing
- Latency: operands accepted at edge N appear on `product` with `out_valid=1` after edge N+1, i.e. valid in cycle N+1.
- Throughput: 1 result per cycle when `out_ready` is held high.
- Capacity: 2 results in flight. With `out_ready=0`, the block accepts 2 results, after which `in_ready=0`.
- `in_ready` rises in the same cycle `out_ready` rises.
- No bubbles are inserted when a stall releases.
- Outputs are registered except `in_ready`.

## Configuration
- `MGER_COMP_EN` defined:
  - stage 2 computes `product = p1 + s1_low + (s1_approx ? COMP_VAL : 0)` in 17 bits;
  - if bit 16 is set, `product` saturates to 16'hFFFF.
- `MGER_COMP_EN` undefined:
  - `in_approx` and `COMP_VAL` are ignored and `product = p1 + s1_low`;
  - `s1_approx` may be optimised away.
- Handshake and latency are identical in both builds.

## Test plan
- Reset check: assert `rst_n=0` with random inputs -> `out_valid=0`, `product=0`, `done_cnt=0`, `in_ready=1`. Release, send `s_high=225`, `s_mid=450`, `s_low=225`, `out_ready=1` -> next cycle `product=16'hFE01`, `out_valid=1`, then `done_cnt=1`.
- Streaming: 8 back-to-back operands with `out_ready=1`, including `s_high=6`, `s_mid=0`, `s_low=0` -> 8 results at 1 per cycle, latency 1 cycle after accept, the example gives 16'h0600.
- Backpressure: hold `out_ready=0` while streaming -> exactly 2 accepts, then `in_ready=0`, with `product` stable. Raise `out_ready` -> same-cycle `in_ready=1`, results delivered in order, no loss or duplication.
- Compensation (`MGER_COMP_EN`): `s_high=225`, `s_mid=450`, `s_low=225`, `in_approx=1`, `COMP_VAL=16'd1000` -> `product=16'hFFFF`. Same with `in_approx=0` -> 16'hFE01.
- Counter wrap: `CNT_W=4`, deliver 17 results -> `done_cnt=1`.
- Mid-stream reset: assert `rst_n` low while 2 results are held under a stall -> outputs clear asynchronously. After release, the first new result is the only one delivered.
